// File: rtl/tank_sensor_model_pkg.sv
// Shared encodings for the tank model and the sistemaNivel checks:
// level states carry their H/M/L sensor code directly.
package tank_sensor_model_pkg;

    typedef enum logic [2:0] {
        VAZIO = 3'b000,
        BAIXO = 3'b001,
        MEDIO = 3'b011,
        CHEIO = 3'b111
    } level_t;

    typedef enum logic [1:0] {
        FAULT_NONE = 2'b00,
        FAULT_L0   = 2'b01,
        FAULT_M1   = 2'b10,
        FAULT_H1   = 2'b11
    } fault_t;

endpackage

// File: rtl/tank_sensor_model_tick.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, in the cycle where the count sits at TICK_DIV-1.
module tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/tank_sensor_model.sv
// Plant-side water tank: integrates inlet/outflow into a saturating volume and
// drives hysteretic H/M/L sensors, with stuck-sensor fault injection.
module tank_sensor_model
    import tank_sensor_model_pkg::*;
#(
    parameter int VOL_W      = 8,
    parameter int VOL_MAX    = 200,
    parameter int L_TH       = 20,
    parameter int M_TH       = 100,
    parameter int H_TH       = 180,
    parameter int HYST       = 4,
    parameter int TICK_DIV   = 4,
    parameter int FILL_STEP  = 2,
    parameter int DRAIN_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Ve,
    input  logic             Vs,
    input  logic [1:0]       fault_sel,
    output logic             H,
    output logic             M,
    output logic             L,
    output logic [VOL_W-1:0] nivel,
    output logic             transbordo,
    output logic             seco
);
    localparam int SW = VOL_W + 2;
    localparam logic signed [SW-1:0] ZERO_S  = '0;
    localparam logic signed [SW-1:0] MAX_S   = SW'(VOL_MAX);
    localparam logic signed [SW-1:0] FILL_S  = SW'(FILL_STEP);
    localparam logic signed [SW-1:0] DRAIN_S = SW'(DRAIN_STEP);
    localparam logic [VOL_W-1:0] MAX_V = VOL_W'(VOL_MAX);
    localparam logic [VOL_W-1:0] L_UP  = VOL_W'(L_TH);
    localparam logic [VOL_W-1:0] M_UP  = VOL_W'(M_TH);
    localparam logic [VOL_W-1:0] H_UP  = VOL_W'(H_TH);
    localparam logic [VOL_W-1:0] L_DN  = VOL_W'(L_TH - HYST);
    localparam logic [VOL_W-1:0] M_DN  = VOL_W'(M_TH - HYST);
    localparam logic [VOL_W-1:0] H_DN  = VOL_W'(H_TH - HYST);

    logic                 tick;
    logic [VOL_W-1:0]     volume;
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] v_sum;
    level_t               state;
    level_t               state_next;
    logic [2:0]           hml;

    function automatic logic [VOL_W-1:0] sat_volume(input logic signed [SW-1:0] v);
        if (v < ZERO_S) return '0;
        if (v > MAX_S) return MAX_V;
        return v[VOL_W-1:0];
    endfunction

    function automatic logic [2:0] apply_fault(input level_t lvl, input logic [1:0] sel);
        logic [2:0] code;
        code = lvl;
        case (sel)
            FAULT_L0: code[0] = 1'b0;
            FAULT_M1: code[1] = 1'b1;
            FAULT_H1: code[2] = 1'b1;
            default:  code = lvl;
        endcase
        return code;
    endfunction

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        step = ZERO_S;
        if (Ve) step = step + FILL_S;
        if (Vs) step = step - DRAIN_S;
        v_sum = $signed({2'b00, volume}) + step;
    end

    // Volume integrator: overflow pulse only when a net fill is refused at the ceiling
    always_ff @(posedge clk) begin
        if (reset) begin
            volume     <= '0;
            transbordo <= 1'b0;
        end else begin
            transbordo <= tick && Ve && (volume == MAX_V) && (step > ZERO_S);
            if (tick) volume <= sat_volume(v_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= VAZIO;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            VAZIO: if (volume >= L_UP) state_next = BAIXO;
            BAIXO: begin
                if (volume >= M_UP)      state_next = MEDIO;
                else if (volume < L_DN)  state_next = VAZIO;
            end
            MEDIO: begin
                if (volume >= H_UP)      state_next = CHEIO;
                else if (volume < M_DN)  state_next = BAIXO;
            end
            CHEIO: if (volume < H_DN) state_next = MEDIO;
            default: state_next = VAZIO;
        endcase
    end

    // Sensor register: faults only mask the outputs, never the state they came from
    always_ff @(posedge clk) begin
        if (reset) hml <= 3'b000;
        else       hml <= apply_fault(state, fault_sel);
    end

    assign {H, M, L} = hml;
    assign nivel     = volume;
    assign seco      = (volume == '0);

endmodule

// File: tb/tb_tank_sensor_model.sv
// Directed bench for tank_sensor_model: one long fill/drain/fault scenario from a
// vector table, plus hand sequences for saturation pulses and mid-fill reset.
module tb_tank_sensor_model;

    logic       clk;
    logic       reset;
    logic       Ve;
    logic       Vs;
    logic [1:0] fault_sel;
    logic       H, M, L;
    logic [7:0] nivel;
    logic       transbordo;
    logic       seco;

    int tests;
    int failed;

    typedef struct {
        int         n;
        bit         ve;
        bit         vs;
        logic [1:0] fs;
        int         nivel;
        logic [2:0] hml;
        bit         seco;
        bit         trans;
    } vec_t;

    vec_t rows[28];

    tank_sensor_model dut (
        .clk        (clk),
        .reset      (reset),
        .Ve         (Ve),
        .Vs         (Vs),
        .fault_sel  (fault_sel),
        .H          (H),
        .M          (M),
        .L          (L),
        .nivel      (nivel),
        .transbordo (transbordo),
        .seco       (seco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            Ve        = rows[i].ve;
            Vs        = rows[i].vs;
            fault_sel = rows[i].fs;
            step(rows[i].n);
            check($sformatf("row%0d nivel", i), int'(nivel), rows[i].nivel);
            check($sformatf("row%0d HML", i), int'({H, M, L}), int'(rows[i].hml));
            check($sformatf("row%0d seco", i), int'(seco), int'(rows[i].seco));
            check($sformatf("row%0d transbordo", i), int'(transbordo), int'(rows[i].trans));
        end
    endtask

    initial begin
        int pulses;
        tests  = 0;
        failed = 0;

        // fill from reset (tick every 4th edge after release)
        rows[0]  = '{3,   1, 0, 2'b00, 0,   3'b000, 1, 0};
        rows[1]  = '{1,   1, 0, 2'b00, 2,   3'b000, 0, 0};
        rows[2]  = '{36,  1, 0, 2'b00, 20,  3'b000, 0, 0};
        rows[3]  = '{1,   1, 0, 2'b00, 20,  3'b000, 0, 0};
        rows[4]  = '{1,   1, 0, 2'b00, 20,  3'b001, 0, 0};
        rows[5]  = '{158, 1, 0, 2'b00, 100, 3'b001, 0, 0};
        rows[6]  = '{2,   1, 0, 2'b00, 100, 3'b011, 0, 0};
        rows[7]  = '{158, 1, 0, 2'b00, 180, 3'b011, 0, 0};
        rows[8]  = '{2,   1, 0, 2'b00, 180, 3'b111, 0, 0};
        rows[9]  = '{38,  1, 0, 2'b00, 200, 3'b111, 0, 0};
        // drain with hysteresis
        rows[10] = '{96,  0, 1, 2'b00, 176, 3'b111, 0, 0};
        rows[11] = '{4,   0, 1, 2'b00, 175, 3'b111, 0, 0};
        rows[12] = '{1,   0, 1, 2'b00, 175, 3'b111, 0, 0};
        rows[13] = '{1,   0, 1, 2'b00, 175, 3'b011, 0, 0};
        rows[14] = '{314, 0, 1, 2'b00, 96,  3'b011, 0, 0};
        rows[15] = '{4,   0, 1, 2'b00, 95,  3'b011, 0, 0};
        rows[16] = '{2,   0, 1, 2'b00, 95,  3'b001, 0, 0};
        rows[17] = '{178, 0, 1, 2'b00, 50,  3'b001, 0, 0};
        // simultaneous Ve/Vs: net +1 per tick
        rows[18] = '{4,   1, 1, 2'b00, 51,  3'b001, 0, 0};
        rows[19] = '{4,   1, 1, 2'b00, 52,  3'b001, 0, 0};
        // faults at MEDIO, then at BAIXO
        rows[20] = '{136, 1, 0, 2'b00, 120, 3'b011, 0, 0};
        rows[21] = '{1,   0, 0, 2'b01, 120, 3'b010, 0, 0};
        rows[22] = '{1,   0, 0, 2'b11, 120, 3'b111, 0, 0};
        rows[23] = '{1,   0, 0, 2'b00, 120, 3'b011, 0, 0};
        rows[24] = '{99,  0, 1, 2'b00, 95,  3'b001, 0, 0};
        rows[25] = '{1,   0, 0, 2'b10, 95,  3'b011, 0, 0};
        rows[26] = '{1,   0, 0, 2'b00, 95,  3'b001, 0, 0};
        rows[27] = '{20,  0, 1, 2'b00, 90,  3'b001, 0, 0};

        reset     = 1'b1;
        Ve        = 1'b0;
        Vs        = 1'b0;
        fault_sel = 2'b00;
        step(2);
        check("reset nivel", int'(nivel), 0);
        check("reset HML", int'({H, M, L}), 0);
        check("reset seco", int'(seco), 1);
        check("reset transbordo", int'(transbordo), 0);

        reset = 1'b0;
        run_rows(0, 9);

        // at the ceiling: one transbordo pulse per tick, volume held
        Ve     = 1'b1;
        Vs     = 1'b0;
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            step(1);
            if (transbordo) pulses++;
        end
        check("sat pulses", pulses, 4);
        check("sat nivel", int'(nivel), 200);
        check("sat HML", int'({H, M, L}), 7);

        run_rows(10, 27);

        // reset mid-fill at nivel 90
        Ve    = 1'b1;
        Vs    = 1'b0;
        reset = 1'b1;
        step(1);
        check("midrst nivel", int'(nivel), 0);
        check("midrst HML", int'({H, M, L}), 0);
        check("midrst seco", int'(seco), 1);
        check("midrst transbordo", int'(transbordo), 0);
        reset = 1'b0;
        step(3);
        check("midrst no early tick", int'(nivel), 0);
        step(1);
        check("midrst first tick", int'(nivel), 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
